// File: rtl/uart_fifo_pkg.sv
// Register map and bit positions for the FIFO-backed UART register interface.
package uart_fifo_pkg;

    // Word offsets, compared against addr[15:2]
    localparam logic [13:0] ADDR_DATA     = 14'h0;
    localparam logic [13:0] ADDR_STATUS   = 14'h1;
    localparam logic [13:0] ADDR_CTRL     = 14'h2;
    localparam logic [13:0] ADDR_IRQ_CTRL = 14'h3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_RX_NEMPTY  = 1;
    localparam int ST_RX_OVF     = 2;
    localparam int ST_TX_OVF     = 3;
    localparam int ST_TX_IDLE    = 4;

    localparam int CTRL_FLUSH_RX = 0;
    localparam int CTRL_FLUSH_TX = 1;
    localparam int CTRL_CLR_OVF  = 2;

    localparam int IRQ_RX_IE     = 0;
    localparam int IRQ_TX_IE     = 1;
    localparam int IRQ_OVF_IE    = 2;
    localparam logic [31:0] IRQ_CTRL_RST  = 32'h0000_0100;
    localparam logic [31:0] IRQ_CTRL_MASK = 32'h0000_FF07;

    // A full 256-entry FIFO does not fit the 8-bit count field
    function automatic logic [7:0] sat8(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with occupancy count, flush and a same-cycle drop indicator.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem[rptr];

    // A pop frees the slot the same cycle, so a push to a full FIFO still lands
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;
    assign drop_o  = push_i && full_o && !do_pop && !flush_i;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count_o <= count_o + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver core; samples mid-bit, valid_o held until ready_i.
module uart_rx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;

    logic [1:0]    sync;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    bitn;
    logic [7:0]    shreg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync    <= 2'b11;
            busy    <= 1'b0;
            cnt     <= '0;
            bitn    <= '0;
            shreg   <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            sync <= {sync[0], rx_i};
            if (valid_o && ready_i) valid_o <= 1'b0;
            if (!busy) begin
                if (!sync[1]) begin
                    busy <= 1'b1;
                    cnt  <= CW'(DIV / 2 - 1);
                    bitn <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                // bitn 0 = start check, 1..8 = data LSB first, 9 = stop
                cnt  <= CW'(DIV - 1);
                bitn <= bitn + 1'b1;
                if (bitn == 4'd0) begin
                    if (sync[1]) busy <= 1'b0;
                end else if (bitn <= 4'd8) begin
                    shreg <= {sync[1], shreg[7:1]};
                end else begin
                    busy <= 1'b0;
                    if (sync[1]) begin
                        valid_o <= 1'b1;
                        data_o  <= shreg;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter core; ready_o high while idle, line idles high.
module uart_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       valid_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(DIV) + 1;

    logic          busy;
    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    bitn;

    assign ready_o = !busy;
    assign tx_o    = busy ? shreg[0] : 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy  <= 1'b0;
            shreg <= '1;
            cnt   <= '0;
            bitn  <= '0;
        end else if (!busy) begin
            if (valid_i) begin
                busy  <= 1'b1;
                shreg <= {1'b1, data_i, 1'b0};
                cnt   <= CW'(DIV - 1);
                bitn  <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            cnt <= CW'(DIV - 1);
            if (bitn == 4'd9) busy <= 1'b0;
            else begin
                shreg <= {1'b1, shreg[9:1]};
                bitn  <= bitn + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_fifo_iface.sv
// Memory-mapped UART with RX/TX FIFOs, counts, sticky overflows and flush.
// Optional interrupt logic and IRQ_CTRL register under `UART_FIFO_IRQ_EN.
module uart_fifo_iface
    import uart_fifo_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o
);
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [13:0]      word;
    logic             rd, wr;
    logic             rx_valid, rx_full, rx_empty, rx_drop, rx_ovf;
    logic             tx_full, tx_empty, tx_drop, tx_ovf, tx_ready;
    logic [7:0]       rx_byte, rx_head, tx_head;
    logic [RX_CW-1:0] rx_count;
    logic [TX_CW-1:0] tx_count;
    logic             rx_pop, tx_push, tx_pop;
    logic             flush_rx, flush_tx, clr_ovf;
    logic [31:0]      status, rdata_d;
    logic             unused;

    assign unused   = &{1'b0, addr_i[1:0], wdata_i};
    assign word     = addr_i[15:2];
    assign rd       = req_i && !we_i;
    assign wr       = req_i && we_i;
    assign rx_pop   = rd && (word == ADDR_DATA);
    assign tx_push  = wr && (word == ADDR_DATA);
    assign tx_pop   = !tx_empty && tx_ready;
    assign flush_rx = wr && (word == ADDR_CTRL) && wdata_i[CTRL_FLUSH_RX];
    assign flush_tx = wr && (word == ADDR_CTRL) && wdata_i[CTRL_FLUSH_TX];
    assign clr_ovf  = wr && (word == ADDR_CTRL) && wdata_i[CTRL_CLR_OVF];

`ifdef UART_FIFO_IRQ_EN
    logic [31:0] irq_ctrl;
    logic [7:0]  thresh;
    assign thresh = (irq_ctrl[15:8] == 8'd0) ? 8'd1 : irq_ctrl[15:8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_ctrl <= IRQ_CTRL_RST;
            irq_o    <= 1'b0;
        end else begin
            if (wr && (word == ADDR_IRQ_CTRL)) irq_ctrl <= wdata_i & IRQ_CTRL_MASK;
            irq_o <= (irq_ctrl[IRQ_RX_IE] && (9'(rx_count) >= {1'b0, thresh}))
                  || (irq_ctrl[IRQ_TX_IE] && tx_empty)
                  || (irq_ctrl[IRQ_OVF_IE] && (rx_ovf || tx_ovf));
        end
    end
`else
    assign irq_o = 1'b0;
`endif

    always_comb begin
        status               = '0;
        status[ST_TX_FULL]   = tx_full;
        status[ST_RX_NEMPTY] = !rx_empty;
        status[ST_RX_OVF]    = rx_ovf;
        status[ST_TX_OVF]    = tx_ovf;
        status[ST_TX_IDLE]   = tx_empty && tx_ready;
        status[15:8]         = sat8(9'(rx_count));
        status[23:16]        = sat8(9'(tx_count));
    end

    // Read data reflects state before this cycle's pop/push
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (word)
                ADDR_DATA:     rdata_d = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
                ADDR_STATUS:   rdata_d = status;
`ifdef UART_FIFO_IRQ_EN
                ADDR_IRQ_CTRL: rdata_d = irq_ctrl;
`endif
                default:       rdata_d = '0;
            endcase
        end
    end

    // A new overflow wins over a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rdata_d;
            rx_ovf   <= rx_drop || (rx_ovf && !clr_ovf);
            tx_ovf   <= tx_drop || (tx_ovf && !clr_ovf);
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_rx),
        .push_i(rx_valid), .wdata_i(rx_byte), .pop_i(rx_pop), .rdata_o(rx_head),
        .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count), .drop_o(rx_drop)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_tx),
        .push_i(tx_push), .wdata_i(wdata_i[7:0]), .pop_i(tx_pop), .rdata_o(tx_head),
        .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count), .drop_o(tx_drop)
    );

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk_i(clk_i), .rst_ni(~rst_i), .valid_i(!tx_empty), .data_i(tx_head),
        .ready_o(tx_ready), .tx_o(tx_o)
    );

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk_i(clk_i), .rst_ni(~rst_i), .rx_i(rx_i), .ready_i(1'b1),
        .valid_o(rx_valid), .data_o(rx_byte)
    );

endmodule
